// File: rtl/bumpy_mover.sv
// Per-frame fixed-point motion integrator and death-sequence timer for the Bumpy player.
// Optional macro BUMPY_DIE_BLINK_EN: blink the object while the death sequence runs.
module bumpy_mover #(
  parameter int INITIAL_X              = 64,
  parameter int INITIAL_Y              = 64,
  parameter int FIXED_POINT_MULTIPLIER = 64,
  parameter int X_SPEED                = 128,
  parameter int JUMP_SPEED             = -320,
  parameter int BOUNCE_SPEED           = -192,
  parameter int GRAVITY                = 8,
  parameter int MAX_Y_SPEED            = 384,
  parameter int OBJECT_SIZE            = 32,
  parameter int DIE_FRAMES             = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic [3:0]         state,
  input  logic               bumpy_collision,
  input  logic [3:0]         HitEdgeCode,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic               airborne,
  output logic               die_done,
  output logic               visible
);

  localparam int unsigned POS_W  = 17;
  localparam int unsigned SUM_W  = POS_W + 1;
  localparam int unsigned SPD_W  = 11;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned PIX_W  = 11;
  localparam int unsigned FRAC_W = $clog2(FIXED_POINT_MULTIPLIER);

  localparam logic signed [SUM_W-1:0] X_MAX_FP   = SUM_W'((639 - OBJECT_SIZE) * FIXED_POINT_MULTIPLIER);
  localparam logic signed [SUM_W-1:0] Y_MAX_FP   = SUM_W'((479 - OBJECT_SIZE) * FIXED_POINT_MULTIPLIER);
  localparam logic signed [POS_W-1:0] X_INIT_FP  = POS_W'(INITIAL_X * FIXED_POINT_MULTIPLIER);
  localparam logic signed [POS_W-1:0] Y_INIT_FP  = POS_W'(INITIAL_Y * FIXED_POINT_MULTIPLIER);
  localparam logic signed [SUM_W-1:0] X_STEP     = SUM_W'(X_SPEED);
  localparam logic signed [SPD_W-1:0] SPD_JUMP   = SPD_W'(JUMP_SPEED);
  localparam logic signed [SPD_W-1:0] SPD_BOUNCE = SPD_W'(BOUNCE_SPEED);
  localparam logic signed [SPD_W-1:0] SPD_MAX    = SPD_W'(MAX_Y_SPEED);
  localparam logic signed [SPD_W:0]   SPD_MAX_X  = (SPD_W+1)'(MAX_Y_SPEED);
  localparam logic signed [SPD_W:0]   SPD_GRAV   = (SPD_W+1)'(GRAVITY);
  localparam logic [CNT_W-1:0]        DIE_LAST   = CNT_W'(DIE_FRAMES - 1);

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_IDLE     = 4'd1,
    S_LEFT     = 4'd2,
    S_RIGHT    = 4'd3,
    S_DOWN     = 4'd4,
    S_UP       = 4'd5,
    S_DIE      = 4'd6,
    S_BOUNCE_L = 4'd7,
    S_BOUNCE_R = 4'd8,
    S_BOUNCE_T = 4'd9
  } state_e;

  logic signed [POS_W-1:0] r_xpos, r_ypos;
  logic signed [SPD_W-1:0] r_yspeed;
  logic                    r_hit_l, r_hit_t, r_hit_r, r_hit_b;
  logic [CNT_W-1:0]        r_count;
  logic                    r_airborne, r_die_done, r_visible;

  state_e                  w_state;
  logic                    w_set_l, w_set_t, w_set_r, w_set_b;
  logic                    w_hit_l, w_hit_t, w_hit_r, w_hit_b;
  logic signed [SUM_W-1:0] w_xspeed, w_xsum, w_ysum;
  logic signed [POS_W-1:0] w_xnext, w_ynext;
  logic signed [SPD_W:0]   w_ygrav;
  logic signed [SPD_W-1:0] w_yspeed, w_yspeed_next;
  logic                    w_vis_die;

  assign w_state = state_e'(state);

  // A collision on the frame cycle itself joins the latched hits for that update.
  always_comb begin
    w_set_l = bumpy_collision && (HitEdgeCode == 4'b1000);
    w_set_t = bumpy_collision && (HitEdgeCode == 4'b0100);
    w_set_r = bumpy_collision && (HitEdgeCode == 4'b0010);
    w_set_b = bumpy_collision && (HitEdgeCode == 4'b0001);
    w_hit_l = r_hit_l | w_set_l;
    w_hit_t = r_hit_t | w_set_t;
    w_hit_r = r_hit_r | w_set_r;
    w_hit_b = r_hit_b | w_set_b;
  end

  always_comb begin
    w_xspeed = '0;
    case (w_state)
      S_LEFT, S_BOUNCE_R:  w_xspeed = -X_STEP;
      S_RIGHT, S_BOUNCE_L: w_xspeed = X_STEP;
      default:             w_xspeed = '0;
    endcase
    if ((w_hit_l && w_xspeed[SUM_W-1]) || (w_hit_r && (w_xspeed > 0)))
      w_xspeed = '0;
    w_xsum  = $signed({r_xpos[POS_W-1], r_xpos}) + w_xspeed;
    w_xnext = w_xsum[POS_W-1:0];
    if (w_xsum[SUM_W-1])
      w_xnext = '0;
    else if (w_xsum > X_MAX_FP)
      w_xnext = X_MAX_FP[POS_W-1:0];
  end

  // Bounce impulse, then ceiling stop, otherwise gravity with saturation.
  always_comb begin
    w_ygrav  = $signed({r_yspeed[SPD_W-1], r_yspeed}) + SPD_GRAV;
    w_yspeed = r_yspeed;
    if (w_hit_b && !r_yspeed[SPD_W-1])
      w_yspeed = (w_state == S_UP) ? SPD_JUMP : SPD_BOUNCE;
    else if ((w_hit_t || (w_state == S_BOUNCE_T)) && r_yspeed[SPD_W-1])
      w_yspeed = '0;
    else if (w_ygrav > SPD_MAX_X)
      w_yspeed = SPD_MAX;
    else
      w_yspeed = w_ygrav[SPD_W-1:0];
    w_ysum        = $signed({r_ypos[POS_W-1], r_ypos}) +
                    $signed({{(SUM_W-SPD_W){w_yspeed[SPD_W-1]}}, w_yspeed});
    w_ynext       = w_ysum[POS_W-1:0];
    w_yspeed_next = w_yspeed;
    if (w_ysum[SUM_W-1]) begin
      w_ynext = '0;
    end else if (w_ysum >= Y_MAX_FP) begin
      w_ynext       = Y_MAX_FP[POS_W-1:0];
      w_yspeed_next = '0;
    end
  end

`ifdef BUMPY_DIE_BLINK_EN
  assign w_vis_die = ~r_count[2];
`else
  assign w_vis_die = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_xpos     <= X_INIT_FP;
      r_ypos     <= Y_INIT_FP;
      r_yspeed   <= '0;
      r_hit_l    <= 1'b0;
      r_hit_t    <= 1'b0;
      r_hit_r    <= 1'b0;
      r_hit_b    <= 1'b0;
      r_count    <= '0;
      r_airborne <= 1'b0;
      r_die_done <= 1'b0;
      r_visible  <= 1'b1;
    end else begin
      r_die_done <= 1'b0;
      if (startOfFrame) begin
        r_hit_l <= 1'b0;
        r_hit_t <= 1'b0;
        r_hit_r <= 1'b0;
        r_hit_b <= 1'b0;
        case (w_state)
          S_RESET: begin
            r_xpos     <= X_INIT_FP;
            r_ypos     <= Y_INIT_FP;
            r_yspeed   <= '0;
            r_airborne <= 1'b0;
            r_count    <= '0;
            r_visible  <= 1'b1;
          end
          S_DIE: begin
            r_visible <= w_vis_die;
            // Counter parks one past the last frame so the pulse fires once.
            if (r_count == DIE_LAST) begin
              r_die_done <= 1'b1;
              r_xpos     <= X_INIT_FP;
              r_ypos     <= Y_INIT_FP;
              r_yspeed   <= '0;
              r_airborne <= 1'b0;
              r_count    <= r_count + CNT_W'(1);
            end else if (r_count < DIE_LAST) begin
              r_count <= r_count + CNT_W'(1);
            end
          end
          default: begin
            r_xpos     <= w_xnext;
            r_ypos     <= w_ynext;
            r_yspeed   <= w_yspeed_next;
            r_airborne <= (w_yspeed_next != '0);
            r_count    <= '0;
            r_visible  <= 1'b1;
          end
        endcase
      end else begin
        r_hit_l <= r_hit_l | w_set_l;
        r_hit_t <= r_hit_t | w_set_t;
        r_hit_r <= r_hit_r | w_set_r;
        r_hit_b <= r_hit_b | w_set_b;
      end
    end
  end

  assign topLeftX = PIX_W'(r_xpos >>> FRAC_W);
  assign topLeftY = PIX_W'(r_ypos >>> FRAC_W);
  assign airborne = r_airborne;
  assign die_done = r_die_done;
  assign visible  = r_visible;

endmodule

// File: tb/tb_bumpy_mover.sv
// Bench for bumpy_mover: directed scenarios plus random frames against a frame-level model.
module tb_bumpy_mover;

  localparam int FPM    = 64;
  localparam int SPAWN  = 64 * FPM;
  localparam int XMAXFP = (639 - 32) * FPM;
  localparam int YMAXFP = (479 - 32) * FPM;
  localparam int DIEN   = 30;

  logic               clk;
  logic               reset;
  logic               startOfFrame;
  logic [3:0]         state;
  logic               bumpy_collision;
  logic [3:0]         HitEdgeCode;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               airborne;
  logic               die_done;
  logic               visible;

  bumpy_mover dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .state(state),
    .bumpy_collision(bumpy_collision), .HitEdgeCode(HitEdgeCode),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .airborne(airborne),
    .die_done(die_done), .visible(visible)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int n_pulses = 0;
  int frame_no = 0;
  int pulse_frame = 0;

  // Model state: positions in 1/64 px, speeds in 1/64 px per frame.
  int m_x, m_y, m_ys, m_cnt;
  bit m_hl, m_ht, m_hr, m_hb, m_done, m_vis, m_air;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_x = SPAWN; m_y = SPAWN; m_ys = 0; m_cnt = 0;
    m_hl = 0; m_ht = 0; m_hr = 0; m_hb = 0;
    m_done = 0; m_vis = 1; m_air = 0;
  endtask

  task automatic model_clock(input bit rst, input bit sof, input int st, input bit coll, input int code);
    bit sl, stp, sr, sb, hl, ht, hr, hb;
    int xs;
    if (rst) begin
      model_reset();
      return;
    end
    sl  = coll && (code == 8);
    stp = coll && (code == 4);
    sr  = coll && (code == 2);
    sb  = coll && (code == 1);
    m_done = 0;
    if (!sof) begin
      m_hl |= sl; m_ht |= stp; m_hr |= sr; m_hb |= sb;
      return;
    end
    hl = m_hl | sl; ht = m_ht | stp; hr = m_hr | sr; hb = m_hb | sb;
    m_hl = 0; m_ht = 0; m_hr = 0; m_hb = 0;
    if (st == 0) begin
      m_x = SPAWN; m_y = SPAWN; m_ys = 0; m_air = 0; m_cnt = 0; m_vis = 1;
    end else if (st == 6) begin
`ifdef BUMPY_DIE_BLINK_EN
      m_vis = ((m_cnt / 4) % 2) == 0;
`else
      m_vis = 1;
`endif
      if (m_cnt == DIEN - 1) begin
        m_done = 1; m_x = SPAWN; m_y = SPAWN; m_ys = 0; m_air = 0; m_cnt++;
      end else if (m_cnt < DIEN - 1) begin
        m_cnt++;
      end
    end else begin
      m_cnt = 0; m_vis = 1;
      if (st == 2 || st == 8) xs = -128;
      else if (st == 3 || st == 7) xs = 128;
      else xs = 0;
      if ((hl && xs < 0) || (hr && xs > 0)) xs = 0;
      if (hb && m_ys >= 0) m_ys = (st == 5) ? -320 : -192;
      else if ((ht || st == 9) && m_ys < 0) m_ys = 0;
      else m_ys = (m_ys + 8 > 384) ? 384 : m_ys + 8;
      m_y += m_ys;
      m_x += xs;
      if (m_x < 0) m_x = 0;
      if (m_x > XMAXFP) m_x = XMAXFP;
      if (m_y < 0) m_y = 0;
      if (m_y >= YMAXFP) begin m_y = YMAXFP; m_ys = 0; end
      m_air = (m_ys != 0);
    end
  endtask

  task automatic step(input bit rst, input bit sof, input logic [3:0] st, input bit coll, input logic [3:0] code);
    reset = rst; startOfFrame = sof; state = st; bumpy_collision = coll; HitEdgeCode = code;
    @(posedge clk);
    model_clock(rst, sof, int'(st), coll, int'(code));
    if (sof && !rst) frame_no++;
    #1;
    check("x", topLeftX, m_x / FPM);
    check("y", topLeftY, m_y / FPM);
    check("airborne", airborne, m_air);
    check("die_done", die_done, m_done);
    check("visible", visible, m_vis);
    if (die_done === 1'b1) begin
      n_pulses++;
      pulse_frame = frame_no;
    end
  endtask

  task automatic frame(input logic [3:0] st);
    step(0, 0, st, 0, 4'd0);
    step(0, 1, st, 0, 4'd0);
  endtask

  initial begin
    int hold, gap;
    logic [3:0] cur, code;
    bit coll;
    hold = 0; cur = 4'd1;
    model_reset();

    step(1, 0, 4'd0, 0, 4'd0);
    step(1, 1, 4'd3, 0, 4'd0);
    check("rst_x", topLeftX, 64);
    check("rst_y", topLeftY, 64);
    check("rst_air", airborne, 0);
    check("rst_done", die_done, 0);
    check("rst_vis", visible, 1);

    repeat (5) frame(4'd0);
    check("sreset_x", topLeftX, 64);
    check("sreset_y", topLeftY, 64);
    check("sreset_air", airborne, 0);

    repeat (10) frame(4'd3);
    check("right10_x", topLeftX, 84);
    check("right10_y", topLeftY, 70);

    step(0, 0, 4'd5, 1, 4'b0001);
    step(0, 1, 4'd5, 0, 4'd0);
    check("jump_y", topLeftY, 65);
    check("jump_air", airborne, 1);

    repeat (45) frame(4'd1);
    step(0, 0, 4'd1, 1, 4'b0001);
    step(0, 1, 4'd1, 0, 4'd0);

    step(0, 0, 4'd2, 1, 4'b1000);
    step(0, 1, 4'd2, 0, 4'd0);
    check("left_blocked_x", topLeftX, 84);
    step(0, 0, 4'd7, 1, 4'b1000);
    step(0, 1, 4'd7, 0, 4'd0);
    check("bounce_left_x", topLeftX, 86);

    frame(4'd1);
    n_pulses = 0; frame_no = 0; pulse_frame = 0;
    repeat (DIEN) frame(4'd6);
    check("die_pulses", n_pulses, 1);
    check("die_pulse_frame", pulse_frame, DIEN);
    check("die_x", topLeftX, 64);
    check("die_y", topLeftY, 64);
    frame(4'd1);

    repeat (5) frame(4'd3);
    n_pulses = 0;
    repeat (15) frame(4'd6);
    step(1, 1, 4'd6, 0, 4'd0);
    repeat (20) frame(4'd6);
    check("die_abort_pulses", n_pulses, 0);
    repeat (2) frame(4'd1);

    for (int i = 0; i < 8; i++) begin
      frame(4'd6);
`ifdef BUMPY_DIE_BLINK_EN
      check("blink", visible, (i < 4) ? 1 : 0);
`else
      check("blink", visible, 1);
`endif
    end
    frame(4'd1);
    check("vis_after_die", visible, 1);

    repeat (300) frame(4'd3);
    check("xmax", topLeftX, 607);
    check("yfloor", topLeftY, 447);
    check("floor_air", airborne, 0);
    repeat (320) frame(4'd2);
    check("xmin", topLeftX, 0);

    for (int f = 0; f < 400; f++) begin
      if (hold == 0) begin
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) cur = 4'd0;
        else if (r == 1) cur = 4'd6;
        else begin
          cur = 4'($urandom_range(1, 9));
          if (cur == 4'd6) cur = 4'd9;
        end
        hold = $urandom_range(1, 6);
      end
      hold--;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        coll = ($urandom_range(0, 2) == 0);
        code = ($urandom_range(0, 9) < 7) ? 4'(4'b0001 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        step(0, 0, 4'($urandom_range(0, 9)), coll, code);
      end
      coll = ($urandom_range(0, 2) == 0);
      code = 4'(4'b0001 << $urandom_range(0, 3));
      step($urandom_range(0, 99) == 0, 1, cur, coll, code);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
